// File: rtl/entrada_handshake_if.sv
// Signal bundle between the board-side input pins / control unit and the
// user-input front-end. The block itself connects through the slave modport;
// whatever drives the button, switches and request uses the master modport.
interface entrada_handshake_if #(
  parameter int WIDTH = 18
);
  logic             enter;
  logic [WIDTH-1:0] entrada;
  logic             in;
  logic             sinal;
  logic [WIDTH-1:0] valor;
  logic             aguardando;

  modport master (
    output enter, entrada, in,
    input  sinal, valor, aguardando
  );

  modport slave (
    input  enter, entrada, in,
    output sinal, valor, aguardando
  );
endinterface

// File: rtl/entrada_handshake.sv
// User-input front-end: synchronizes and debounces the enter button,
// double-registers the switch word and runs the press/release handshake with
// the control unit's request, producing one committed word per request.
module entrada_handshake #(
  parameter int WIDTH            = 18,
  parameter int DEBOUNCE_CYCLES  = 16,
  parameter bit ENTER_ACTIVE_LOW = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  entrada_handshake_if.slave bus
);

  localparam logic [15:0] deb_last = 16'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ARMED,
    HELD,
    COMMIT,
    WAIT_DROP
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             press_raw;
  logic             press_sync1;
  logic             press_sync2;
  logic [WIDTH-1:0] word_sync1;
  logic [WIDTH-1:0] word_sync2;
  logic             deb_pressed;
  logic [15:0]      deb_count;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] valor_q;
  logic             capture;
  logic             commit;

  // The button polarity is folded in here so everything downstream sees 1 = pressed.
  assign press_raw = bus.enter ^ ENTER_ACTIVE_LOW;

  // Two-flop synchronizers for the button and the switch word.
  always_ff @(posedge clock) begin
    if (reset) begin
      press_sync1 <= 1'b0;
      press_sync2 <= 1'b0;
      word_sync1  <= '0;
      word_sync2  <= '0;
    end else begin
      press_sync1 <= press_raw;
      press_sync2 <= press_sync1;
      word_sync1  <= bus.entrada;
      word_sync2  <= word_sync1;
    end
  end

  // Accept a new button level only after it has disagreed with the current one for DEBOUNCE_CYCLES samples.
  always_ff @(posedge clock) begin
    if (reset) begin
      deb_pressed <= 1'b0;
      deb_count   <= '0;
    end else if (press_sync2 == deb_pressed) begin
      deb_count <= '0;
    end else if (deb_count == deb_last) begin
      deb_pressed <= ~deb_pressed;
      deb_count   <= '0;
    end else begin
      deb_count <= deb_count + 16'd1;
    end
  end

  // Handshake state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a dropped request always wins so a withdrawn request never commits.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in) begin
          state_next = deb_pressed ? CLEAR : ARMED;
        end
      end
      CLEAR: begin
        if (!bus.in) begin
          state_next = IDLE;
        end else if (!deb_pressed) begin
          state_next = ARMED;
        end
      end
      ARMED: begin
        if (!bus.in) begin
          state_next = IDLE;
        end else if (deb_pressed) begin
          state_next = HELD;
          capture    = 1'b1;
        end
      end
      HELD: begin
        if (!bus.in) begin
          state_next = IDLE;
        end else if (!deb_pressed) begin
          state_next = COMMIT;
          commit     = 1'b1;
        end
      end
      COMMIT: begin
        state_next = WAIT_DROP;
      end
      WAIT_DROP: begin
        if (!bus.in) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Word captured at the press edge; loaded into valor on the edge entering COMMIT so it is already new while sinal is high.
  always_ff @(posedge clock) begin
    if (reset) begin
      shadow  <= '0;
      valor_q <= '0;
    end else begin
      if (capture) begin
        shadow <= word_sync2;
      end
      if (commit) begin
        valor_q <= shadow;
      end
    end
  end

  assign bus.sinal      = (state == COMMIT);
  assign bus.aguardando = (state == ARMED) || (state == HELD);
  assign bus.valor      = valor_q;

endmodule
